// File: rtl/pipe_adder.sv
// Carry-chunked pipelined adder/subtractor with valid/ready handshake.
// Each stage adds one CHUNK-wide slice; the carry between slices is always registered.

module pipe_adder_stage #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ovf_o
);
  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0] part;
  logic           unused_bits;

  assign part = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_i};

  // Earlier chunks pass through untouched; only this stage's slice is written.
  always_comb begin
    s_o = s_i;
    s_o[LO +: CHUNK] = part[CHUNK-1:0];
  end

  assign c_o   = part[CHUNK];
  assign ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (s_o[WIDTH-1] != a_i[WIDTH-1]);

  assign unused_bits = ^{a_i, b_i, s_i};
endmodule

module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_cnt
);
  localparam int CHUNK = WIDTH / STAGES;

  logic                          advance;
  // *_in[k] feeds stage k; *_q[k] is the register stage k loads.
  logic [STAGES-1:0][WIDTH-1:0]  a_in, b_in, s_in, s_d;
  logic [STAGES-1:0]             c_in, v_in, c_d, ovf_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic [STAGES-1:0]             c_q, vld_q;
  logic                          ovf_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          unused_bits;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_first
      // Subtract folds into add: invert b and the carry-in once at entry.
      assign a_in[k] = a;
      assign b_in[k] = b ^ {WIDTH{sub}};
      assign s_in[k] = '0;
      assign c_in[k] = cin ^ sub;
      assign v_in[k] = in_valid;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = vld_q[k-1];
    end

    pipe_adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
      .a_i   (a_in[k]),
      .b_i   (b_in[k]),
      .s_i   (s_in[k]),
      .c_i   (c_in[k]),
      .s_o   (s_d[k]),
      .c_o   (c_d[k]),
      .ovf_o (ovf_d[k])
    );
  end

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      vld_q <= v_in;
      a_q   <= a_in;
      b_q   <= b_in;
      s_q   <= s_d;
      c_q   <= c_d;
      ovf_q <= ovf_d[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign done_cnt  = cnt_q;

  // Final-stage operand copies and lower-stage overflow terms have no consumer.
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], ovf_d};
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: driver pushes expected results, monitor pops on output transfer.
module tb_pipe_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;
  logic [CNT_W-1:0] done_cnt;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t             q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] cnt_model;
  logic             prev_stall;
  res_t             prev;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned/signed values.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    res_t   r;
    longint ux, uy, sx, sy, lc, sr, ur;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lc = longint'(c);
    if (!s) begin
      ur     = ux + uy + lc;
      sr     = sx + sy + lc;
      r.cout = (ur >= 64'sd4294967296);
    end else begin
      ur     = ux - uy - lc;
      sr     = sx - sy - lc;
      r.cout = (ux >= uy + lc);
    end
    r.sum = 32'(ur);
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  // Drive one cycle's inputs at the falling edge; returns whether the next rising edge accepts.
  task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic s, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = v; a = x; b = y; cin = c; sub = s; out_ready = ordy;
    #1;
    acc = v && in_ready && rst_n;
    if (acc) q.push_back(model(x, y, c, s));
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 200 && q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    res_t e;
    #2;
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_done_cnt", 64'(done_cnt), 64'd0);
      cnt_model  = '0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      chk("done_cnt", 64'(done_cnt), 64'(cnt_model));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({sum, cout, ovf}), 64'(prev));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("cout", 64'(cout), 64'(e.cout));
          chk("ovf", 64'(ovf), 64'(e.ovf));
        end
        cnt_model = cnt_model + CNT_W'(1);
      end
      prev_stall = out_valid && !out_ready;
      prev       = '{sum: sum, cout: cout, ovf: ovf};
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic        acc;
    int          stalls, sent;
    logic [CNT_W-1:0] base, delta;
    logic [31:0] dx[6], dy[6];
    logic        dc[6], ds[6];
    logic [31:0] x, y;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout_ovf", 64'({cout, ovf}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // First op after reset: latency STAGES-1 edges past acceptance, count follows one edge later.
    cycle(1'b1, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1, acc);
    chk("first_accept", 64'(acc), 64'd1);
    for (int k = 1; k <= STAGES; k++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      chk("latency_valid", 64'(out_valid), 64'(k == STAGES));
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk("done_cnt_first", 64'(done_cnt), 64'd1);

    // Borrow/overflow/carry-ripple corners, issued back to back.
    dx = '{32'd5, 32'd10, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00FF00FF};
    dy = '{32'd10, 32'd5, 32'd1, 32'd1, 32'd1, 32'hFF00FF01};
    dc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ds = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) cycle(1'b1, dx[i], dy[i], dc[i], ds[i], 1'b1, acc);
    drain();

    // Stream of 8 with a 3-cycle downstream stall in the middle.
    base = done_cnt; stalls = 0; sent = 0;
    for (int t = 0; t < 40 && sent < 8; t++) begin
      cycle(1'b1, 32'(sent), 32'(sent), 1'b0, 1'b0, !(t >= 4 && t < 7), acc);
      if (acc) sent++;
      else     stalls++;
    end
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_stalls", 64'(stalls), 64'd3);
    drain();
    delta = done_cnt - base;
    chk("stream_done_cnt", 64'(delta), 64'd8);

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_sum", 64'(sum), 64'd0);
    chk("async_done_cnt", 64'(done_cnt), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2 * STAGES; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      chk("no_stale", 64'(out_valid), 64'd0);
    end

    // Random regression with bubbles and back-pressure.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: x = 32'hFFFFFFFF;
        1: x = 32'h7FFFFFFF;
        2: x = 32'h80000000;
        3: x = 32'h0;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = 32'hFFFFFFFF;
        1: y = 32'h7FFFFFFF;
        2: y = 32'h80000000;
        3: y = 32'h1;
        default: y = $urandom;
      endcase
      cycle($urandom_range(0, 3) != 0, x, y, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
